// File: rtl/pong_pkg.sv
// -----------------------------------------------------------------------------
// pong_pkg
//   Shared definitions for the pong score datapath: game-flow FSM encoding,
//   score width/limit (the display scanner uses the same width), player ids
//   and a saturating score increment helper.
// -----------------------------------------------------------------------------
package pong_pkg;

  // Score width is shared with the seven-segment scanner and the renderer.
  localparam int SCORE_W = 16;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 16'd9999;

  // Player ids; also used as serve direction (0 = toward P1, 1 = toward P2).
  localparam logic PLAYER_1 = 1'b0;
  localparam logic PLAYER_2 = 1'b1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SERVE     = 3'd1,
    PLAY      = 3'd2,
    SCORED    = 3'd3,
    GAME_OVER = 3'd4
  } state_t;

  // Increment a score, holding at SCORE_MAX so the decimal display never wraps.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s >= SCORE_MAX) ? SCORE_MAX : s + 1'b1;
  endfunction

endpackage

// File: rtl/score_controller_point_arbiter.sv
// -----------------------------------------------------------------------------
// point_arbiter
//   Two-requester round-robin arbiter for the rally-end pulses. A single pulse
//   wins outright; simultaneous pulses go to the player selected by rr, which
//   then toggles so the next collision favours the other player.
//
// Ports
//   clk, rst      clock, asynchronous active-high reset (rr -> P1 favoured)
//   en            arbitration enabled (only while the rally is in play)
//   clear         force rr back to P1 favoured (game restart)
//   req_p1/req_p2 one-cycle point pulses from the collision logic
//   scorer_valid  a point was won this cycle
//   scorer_id     winner of the point (PLAYER_1 / PLAYER_2)
// -----------------------------------------------------------------------------
module point_arbiter
  import pong_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  input  logic req_p1,
  input  logic req_p2,
  output logic scorer_valid,
  output logic scorer_id
);

  logic rr;
  logic collision;

  always_comb begin
    collision    = en & req_p1 & req_p2;
    scorer_valid = en & (req_p1 | req_p2);
    scorer_id    = collision ? rr : (req_p2 ? PLAYER_2 : PLAYER_1);
  end

  // rr only moves on a genuine collision; single pulses leave fairness alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr <= PLAYER_1;
    end else if (clear) begin
      rr <= PLAYER_1;
    end else if (collision) begin
      rr <= ~rr;
    end
  end

endmodule

// File: rtl/score_controller.sv
// -----------------------------------------------------------------------------
// score_controller
//   Game-flow controller: sequences each rally (IDLE, SERVE, PLAY, SCORED,
//   GAME_OVER), arbitrates the point pulses, owns both binary scores and gates
//   the ball engine. Every output is registered.
//
// Parameters
//   WIN_SCORE    score that ends the game (1..9999)
//   SERVE_DELAY  cycles spent in SERVE before ball_en rises (>= 1)
//   BLINK_DIV    game-over blink half-period in cycles (SCORE_BLINK_EN only)
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   start_btn            debounced start/restart level; acted on at its rise
//   point_p1, point_p2   one-cycle rally-won pulses
//   score1, score2       player scores, binary 0..9999
//   ball_en              ball engine runs while high
//   serve_dir            0 = serve toward P1, 1 = toward P2
//   game_over, winner    game finished / who won (0 = P1, 1 = P2)
//   disp_en              score digit enable
//
// Build option
//   SCORE_BLINK_EN  when defined, disp_en flashes every BLINK_DIV cycles in
//                   GAME_OVER; otherwise disp_en is tied high.
// -----------------------------------------------------------------------------
module score_controller
  import pong_pkg::*;
#(
  parameter int WIN_SCORE   = 7,
  parameter int SERVE_DELAY = 100000000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_btn,
  input  logic               point_p1,
  input  logic               point_p2,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic               ball_en,
  output logic               serve_dir,
  output logic               game_over,
  output logic               winner,
  output logic               disp_en
);

  if (WIN_SCORE < 1 || WIN_SCORE > 9999 || SERVE_DELAY < 1 || BLINK_DIV < 1) begin : g_param_check
    $error("score_controller: parameter out of legal range");
  end

  localparam int CNT_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
  localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_DELAY - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

  state_t             state, state_d;
  logic [CNT_W-1:0]   serve_cnt, serve_cnt_d;
  logic               start_q, start_rise;
  logic               scorer_q, scorer_d;
  logic               scorer_valid, scorer_id;
  logic               arb_clear;
  logic [SCORE_W-1:0] score1_d, score2_d, new_score;
  logic               ball_en_d, serve_dir_d, game_over_d, winner_d;

  // Level button -> single-cycle rise; holding the button serves only once.
  assign start_rise = start_btn & ~start_q;

  point_arbiter u_point_arbiter (
    .clk          (clk),
    .rst          (rst),
    .en           (state == PLAY),
    .clear        (arb_clear),
    .req_p1       (point_p1),
    .req_p2       (point_p2),
    .scorer_valid (scorer_valid),
    .scorer_id    (scorer_id)
  );

  // NOTE: every variable gets its hold value first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d     = state;
    serve_cnt_d = serve_cnt;
    scorer_d    = scorer_q;
    score1_d    = score1;
    score2_d    = score2;
    serve_dir_d = serve_dir;
    game_over_d = game_over;
    winner_d    = winner;
    arb_clear   = 1'b0;
    new_score   = '0;

    unique case (state)
      IDLE: begin
        if (start_rise) begin
          state_d     = SERVE;
          serve_cnt_d = '0;
        end
      end

      SERVE: begin
        if (serve_cnt == SERVE_LAST) begin
          state_d = PLAY;
        end else begin
          serve_cnt_d = serve_cnt + 1'b1;
        end
      end

      PLAY: begin
        if (scorer_valid) begin
          state_d  = SCORED;
          scorer_d = scorer_id;
        end
      end

      SCORED: begin
        new_score = (scorer_q == PLAYER_2) ? sat_inc(score2) : sat_inc(score1);
        if (scorer_q == PLAYER_2) begin
          score2_d = new_score;
        end else begin
          score1_d = new_score;
        end
        // The player who lost the point receives the next serve.
        serve_dir_d = ~scorer_q;
        if (new_score >= WIN_VAL) begin
          winner_d    = scorer_q;
          game_over_d = 1'b1;
          state_d     = GAME_OVER;
        end else begin
          state_d     = SERVE;
          serve_cnt_d = '0;
        end
      end

      GAME_OVER: begin
        if (start_rise) begin
          score1_d    = '0;
          score2_d    = '0;
          game_over_d = 1'b0;
          serve_dir_d = PLAYER_1;
          arb_clear   = 1'b1;
          state_d     = SERVE;
          serve_cnt_d = '0;
        end
      end

      default: state_d = IDLE;
    endcase

    // Registered from the next state so ball_en tracks PLAY with no lag.
    ball_en_d = (state_d == PLAY);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      serve_cnt <= '0;
      start_q   <= 1'b0;
      scorer_q  <= PLAYER_1;
      score1    <= '0;
      score2    <= '0;
      ball_en   <= 1'b0;
      serve_dir <= PLAYER_1;
      game_over <= 1'b0;
      winner    <= PLAYER_1;
    end else begin
      state     <= state_d;
      serve_cnt <= serve_cnt_d;
      start_q   <= start_btn;
      scorer_q  <= scorer_d;
      score1    <= score1_d;
      score2    <= score2_d;
      ball_en   <= ball_en_d;
      serve_dir <= serve_dir_d;
      game_over <= game_over_d;
      winner    <= winner_d;
    end
  end

`ifdef SCORE_BLINK_EN
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [BLINK_W-1:0] blink_cnt, blink_cnt_d;
  logic               disp_en_d;

  // Blink only while staying in GAME_OVER; the entering and leaving cycles
  // force the display on with a fresh counter.
  always_comb begin
    blink_cnt_d = '0;
    disp_en_d   = 1'b1;
    if (state == GAME_OVER && state_d == GAME_OVER) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt_d = '0;
        disp_en_d   = ~disp_en;
      end else begin
        blink_cnt_d = blink_cnt + 1'b1;
        disp_en_d   = disp_en;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      disp_en   <= 1'b1;
    end else begin
      blink_cnt <= blink_cnt_d;
      disp_en   <= disp_en_d;
    end
  end
`else
  assign disp_en = 1'b1;
`endif

endmodule

// File: tb/tb_score_controller.sv
// -----------------------------------------------------------------------------
// tb_score_controller
//   Self-checking bench for score_controller (SERVE_DELAY=4, WIN_SCORE=3,
//   BLINK_DIV=2). A rally-level model (scores, collision count, winner,
//   serve direction, cycles spent in game over) supplies every expectation.
//   Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_score_controller;

  localparam int WIN = 3;
  localparam int SD  = 4;
  localparam int BD  = 2;

  logic        clk, rst, start_btn, point_p1, point_p2;
  logic [15:0] score1, score2;
  logic        ball_en, serve_dir, game_over, winner, disp_en;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model, expressed in rally terms.
  int m_s1, m_s2, m_coll, go_cycles;
  bit m_over, m_win, m_dir;

  score_controller #(
    .WIN_SCORE   (WIN),
    .SERVE_DELAY (SD),
    .BLINK_DIV   (BD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start_btn (start_btn),
    .point_p1  (point_p1),
    .point_p2  (point_p2),
    .score1    (score1),
    .score2    (score2),
    .ball_en   (ball_en),
    .serve_dir (serve_dir),
    .game_over (game_over),
    .winner    (winner),
    .disp_en   (disp_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic model_new_game();
    m_s1 = 0; m_s2 = 0; m_coll = 0; m_over = 0; m_win = 0; m_dir = 0;
  endtask

  function automatic bit exp_disp(input int k);
`ifdef SCORE_BLINK_EN
    return ((k / BD) % 2) == 0;
`else
    return (k >= 0) || (k < 0);
`endif
  endfunction

  // Waits out the serve (ball_en must rise exactly SD cycles after entry) while
  // injecting pulses that must be discarded.
  task automatic wait_for_play(input string tag);
    for (int k = 1; k <= SD; k++) begin
      @(negedge clk);
      point_p1 = 1'b0; point_p2 = 1'b0;
      n_tests++;
      if (ball_en !== (k == SD)) begin
        n_fail++;
        $display("FAIL %s serve ball_en k=%0d: got %b expected %b", tag, k, ball_en, (k == SD));
      end
      n_tests++;
      if ({score1, score2} !== {16'(m_s1), 16'(m_s2)}) begin
        n_fail++;
        $display("FAIL %s serve scores: got %0d/%0d expected %0d/%0d", tag, score1, score2, m_s1, m_s2);
      end
      if (k < SD && $urandom_range(0, 1) == 1) begin
        point_p1 = 1'($urandom_range(0, 1));
        point_p2 = ~point_p1 | 1'($urandom_range(0, 1));
      end
    end
  endtask

  // Start-button pulse from IDLE or GAME_OVER; ends with the ball in play.
  task automatic start_game(input string tag);
    start_btn = 1'b1;
    @(negedge clk);
    start_btn = 1'b0;
    model_new_game();
    n_tests++;
    if ({score1, score2, serve_dir, game_over, ball_en, disp_en} !== {32'd0, 4'b0001}) begin
      n_fail++;
      $display("FAIL %s start: got s=%0d/%0d dir=%b go=%b ball=%b disp=%b expected 0/0 0 0 0 1",
               tag, score1, score2, serve_dir, game_over, ball_en, disp_en);
    end
    wait_for_play(tag);
  endtask

  task automatic hold_game_over(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      point_p1 = 1'b0; point_p2 = 1'b0;
      go_cycles++;
      n_tests++;
      if ({score1, score2, game_over, winner, ball_en} !== {16'(m_s1), 16'(m_s2), 1'b1, m_win, 1'b0}) begin
        n_fail++;
        $display("FAIL %s frozen: got s=%0d/%0d go=%b win=%b ball=%b expected %0d/%0d 1 %b 0",
                 tag, score1, score2, game_over, winner, ball_en, m_s1, m_s2, m_win);
      end
      n_tests++;
      if (disp_en !== exp_disp(go_cycles)) begin
        n_fail++;
        $display("FAIL %s disp_en k=%0d: got %b expected %b", tag, go_cycles, disp_en, exp_disp(go_cycles));
      end
      if (i < n - 1 && $urandom_range(0, 1) == 1) begin
        point_p1 = 1'b1;
        point_p2 = 1'($urandom_range(0, 1));
      end
    end
  endtask

  // One rally from PLAY: pulse, check latency and result, then serve or stop.
  task automatic do_rally(input bit p1, input bit p2, input string tag);
    int old1, old2, scorer;
    n_tests++;
    if (ball_en !== 1'b1) begin
      n_fail++;
      $display("FAIL %s pre-rally ball_en: got %b expected 1", tag, ball_en);
    end
    repeat ($urandom_range(0, 3)) @(negedge clk);
    point_p1 = p1; point_p2 = p2;
    @(negedge clk);
    point_p1 = 1'b0; point_p2 = 1'b0;
    old1 = m_s1; old2 = m_s2;
    if (p1 && p2) begin
      scorer = m_coll % 2;
      m_coll++;
    end else begin
      scorer = p2 ? 1 : 0;
    end
    if (scorer == 0) m_s1 = (m_s1 < 9999) ? m_s1 + 1 : 9999;
    else             m_s2 = (m_s2 < 9999) ? m_s2 + 1 : 9999;
    m_dir = (scorer == 0);
    if (((scorer == 0) ? m_s1 : m_s2) >= WIN) begin
      m_over = 1'b1;
      m_win  = 1'(scorer);
    end
    n_tests++;
    if ({ball_en, score1, score2} !== {1'b0, 16'(old1), 16'(old2)}) begin
      n_fail++;
      $display("FAIL %s latency N+1: got ball=%b s=%0d/%0d expected 0 %0d/%0d", tag, ball_en, score1, score2, old1, old2);
    end
    @(negedge clk);
    n_tests++;
    if ({score1, score2, serve_dir, game_over, ball_en, disp_en} !==
        {16'(m_s1), 16'(m_s2), m_dir, m_over, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL %s result: got s=%0d/%0d dir=%b go=%b ball=%b disp=%b expected %0d/%0d %b %b 0 1",
               tag, score1, score2, serve_dir, game_over, ball_en, disp_en, m_s1, m_s2, m_dir, m_over);
    end
    if (m_over) begin
      go_cycles = 0;
      n_tests++;
      if (winner !== m_win) begin
        n_fail++;
        $display("FAIL %s winner: got %b expected %b", tag, winner, m_win);
      end
    end else begin
      wait_for_play(tag);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_btn = 1'b0; point_p1 = 1'b0; point_p2 = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({score1, score2, ball_en, serve_dir, game_over, winner, disp_en} !== {32'd0, 5'b00001}) begin
      n_fail++;
      $display("FAIL reset values: got s=%0d/%0d ball=%b dir=%b go=%b win=%b disp=%b expected 0/0 0 0 0 0 1",
               score1, score2, ball_en, serve_dir, game_over, winner, disp_en);
    end
    rst = 1'b0;
    model_new_game();
  endtask

  task automatic test_idle_ignored();
    point_p1 = 1'b1; point_p2 = 1'b1;
    @(negedge clk);
    point_p1 = 1'b0; point_p2 = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({score1, score2, ball_en, game_over} !== 34'd0) begin
      n_fail++;
      $display("FAIL idle points: got s=%0d/%0d ball=%b go=%b expected 0/0 0 0", score1, score2, ball_en, game_over);
    end
  endtask

  // Button held for 10 cycles: one serve only, ball_en exactly SD cycles in.
  task automatic test_serve_timing();
    start_btn = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      point_p1 = (i == 1);
      n_tests++;
      if (ball_en !== (i >= SD + 1)) begin
        n_fail++;
        $display("FAIL serve hold i=%0d: got ball_en=%b expected %b", i, ball_en, (i >= SD + 1));
      end
    end
    start_btn = 1'b0;
    n_tests++;
    if ({score1, score2} !== 32'd0) begin
      n_fail++;
      $display("FAIL serve point ignored: got %0d/%0d expected 0/0", score1, score2);
    end
  endtask

  task automatic test_scoring();
    do_rally(1'b0, 1'b1, "scoring_p2");
  endtask

  task automatic test_collision();
    do_rally(1'b1, 1'b1, "collision_1");
    do_rally(1'b1, 1'b1, "collision_2");
  endtask

  // Asynchronous reset mid-PLAY with score2 = 2, checked with no clock edge.
  task automatic test_reset_mid_play();
    n_tests++;
    if (score2 !== 16'(m_s2) || m_s2 != 2) begin
      n_fail++;
      $display("FAIL pre-reset score2: got %0d expected 2 (model %0d)", score2, m_s2);
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({score1, score2, ball_en, serve_dir, game_over, winner, disp_en} !== {32'd0, 5'b00001}) begin
      n_fail++;
      $display("FAIL async reset: got s=%0d/%0d ball=%b dir=%b go=%b win=%b disp=%b expected 0/0 0 0 0 0 1",
               score1, score2, ball_en, serve_dir, game_over, winner, disp_en);
    end
    @(negedge clk);
    rst = 1'b0;
    model_new_game();
  endtask

  task automatic test_win_restart();
    start_game("win_start");
    for (int r = 0; r < WIN; r++) do_rally(1'b1, 1'b0, "win_p1");
    hold_game_over(6, "win_hold");
    start_game("win_restart");
  endtask

  task automatic test_random();
    for (int g = 0; g < 6; g++) begin
      for (int r = 0; r < 2 * WIN && !m_over; r++) begin
        case ($urandom_range(0, 2))
          0:       do_rally(1'b1, 1'b0, "rand_p1");
          1:       do_rally(1'b0, 1'b1, "rand_p2");
          default: do_rally(1'b1, 1'b1, "rand_both");
        endcase
      end
      hold_game_over($urandom_range(1, 6), "rand_hold");
      start_game("rand_restart");
    end
  endtask

  initial begin
    test_reset();
    test_idle_ignored();
    test_serve_timing();
    test_scoring();
    test_collision();
    test_reset_mid_play();
    test_win_restart();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/score_controller.md
Name: score_controller

Overview:
- Game-flow controller for the score datapath.
- Sequences each rally (idle, serve delay, play, point award, game over) and arbitrates the point-event pulses from the ball/collision logic.
- Owns both players' 16-bit binary scores, which drive the on-screen score renderer and the 8-digit seven-segment scanner directly.
- Gates the ball engine through a ball_en/serve_dir interface.

Parameters:
- WIN_SCORE, 7: score at which a player wins; legal range 1..9999.
- SERVE_DELAY, 100000000: cycles spent in SERVE before ball_en asserts (1 s at 100 MHz); minimum 1.
- BLINK_DIV, 25000000: half-period in cycles of the game-over blink. Used only with SCORE_BLINK_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- start_btn  in  1  debounced, synchronised start/restart button (level).
- point_p1  in  1  one-cycle pulse: player 1 won the rally.
- point_p2  in  1  one-cycle pulse: player 2 won the rally.
- score1  out  16  player 1 score, binary, 0..9999.
- score2  out  16  player 2 score, binary, 0..9999.
- ball_en  out  1  ball engine runs while high; ball re-centres while low.
- serve_dir  out  1  0 = serve toward P1, 1 = serve toward P2.
- game_over  out  1  high in GAME_OVER.
- winner  out  1  0 = P1, 1 = P2; valid while game_over is high.
- disp_en  out  1  score display enable; blanks the score digits when low.

Behaviour:
- Reset values (asynchronous, all registered outputs):
  - state = IDLE; score1 = score2 = 0; ball_en = 0; serve_dir = 0; game_over = 0; winner = 0; disp_en = 1.
  - Serve counter = 0; round-robin priority bit rr = 0 (P1 favoured); start edge register = 0.
- Start edge: start_btn is registered once. start_rise = start_btn & ~start_q. Holding the button produces exactly one rise.
- FSM states: IDLE, SERVE, PLAY, SCORED, GAME_OVER. All outputs are registered.
- IDLE:
  - ball_en = 0; scores held.
  - start_rise -> SERVE; serve counter cleared.
- SERVE:
  - ball_en = 0; counter increments each cycle.
  - When counter == SERVE_DELAY-1 -> PLAY. ball_en is first high on the cycle after that count, i.e. SERVE_DELAY cycles after entry.
- PLAY:
  - ball_en = 1.
  - Single pulse: latch scorer -> SCORED.
  - point_p1 & point_p2 in the same cycle: award to the player selected by rr (rr = 0 -> P1), toggle rr, drop the other pulse -> SCORED. rr toggles only on a collision.
  - start_rise is ignored.
- SCORED (exactly 1 cycle):
  - ball_en = 0.
  - Scorer's score increments by 1, saturating at 9999.
  - serve_dir <= direction toward the player who lost the point.
  - If the new score >= WIN_SCORE: winner <= scorer; game_over <= 1 -> GAME_OVER. Otherwise -> SERVE with the counter cleared.
- GAME_OVER:
  - ball_en = 0; scores frozen.
  - start_rise: score1 = score2 = 0, game_over = 0, serve_dir = 0, rr = 0 -> SERVE.
- Point pulses arriving outside PLAY are discarded and are not queued.
- Point-to-score latency: pulse in cycle N -> score updated and visible at cycle N+2 (N+1 latch/enter SCORED, N+2 registered).
- Reset mid-rally: outputs return to reset values immediately (asynchronous), regardless of state or counter.

Optional Feature:
- Macro: SCORE_BLINK_EN.
- Defined:
  - In GAME_OVER, a BLINK_DIV counter toggles disp_en every BLINK_DIV cycles, starting from 1, to flash the final score.
  - Leaving GAME_OVER or reset forces disp_en = 1 and clears the blink counter.
- Undefined:
  - disp_en is constant 1; no blink counter is synthesised; BLINK_DIV is unused.

Decomposition:
- Shared package pong_pkg:
  - FSM state encoding (3-bit localparams IDLE=0, SERVE=1, PLAY=2, SCORED=3, GAME_OVER=4).
  - SCORE_MAX = 9999; PLAYER_1 = 0, PLAYER_2 = 1.
  - Score width 16, shared with the display scanner.
- One natural sub-module: point_arbiter. It holds the 2-requester round-robin arbiter with the rr bit and produces a scorer_valid/scorer_id pair. Everything else stays in score_controller.

Test Plan:
- Serve timing: SERVE_DELAY=4; rst, release, start_btn high 10 cycles -> SERVE entered once; ball_en rises exactly 4 cycles after SERVE entry; no second serve while the button stays held.
- Scoring: WIN_SCORE=3; in PLAY pulse point_p2 -> score2=1 two cycles later, ball_en low, serve_dir=0; after 4 cycles ball_en=1 again.
- Collision arbitration: simultaneous point_p1 & point_p2 twice (separate rallies) -> first awards score1=1, second awards score2=1; no double increment.
- Win and restart: WIN_SCORE=3, three point_p1 rallies -> score1=3, game_over=1, winner=0, ball_en stays 0; points ignored; start pulse -> scores 0, game_over=0, SERVE.
- Ignored events / reset: point_p1 during SERVE or IDLE -> scores unchanged; assert rst mid-PLAY with score2=2 -> score2=0, ball_en=0 the same cycle without a clock edge.
- SCORE_BLINK_EN defined, BLINK_DIV=2: in GAME_OVER disp_en toggles every 2 cycles; start -> disp_en=1. Undefined: disp_en constant 1.
